// File: rtl/arm_mc_pkg.sv
// arm_mc_pkg: shared encodings for the multicycle ARM control unit.
// Holds the FSM state enum, datapath mux/ALU encodings and the condition checker.
package arm_mc_pkg;

  localparam int ALUCW = 3;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  localparam logic [ALUCW-1:0] ALU_ADD   = 3'b000;
  localparam logic [ALUCW-1:0] ALU_SUB   = 3'b001;
  localparam logic [ALUCW-1:0] ALU_AND   = 3'b010;
  localparam logic [ALUCW-1:0] ALU_ORR   = 3'b011;
  localparam logic [ALUCW-1:0] ALU_EOR   = 3'b100;
  localparam logic [ALUCW-1:0] ALU_PASSB = 3'b101;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_RDATA     = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_8  = 2'b00;
  localparam logic [1:0] IMM_12 = 2'b01;
  localparam logic [1:0] IMM_24 = 2'b10;

  // Flags are packed NZCV, N in bit 3.
  function automatic logic condHolds(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    logic r;
    {n, z, c, v} = flags;
    case (cond)
      COND_EQ: r = z;
      COND_NE: r = ~z;
      COND_CS: r = c;
      COND_CC: r = ~c;
      COND_MI: r = n;
      COND_PL: r = ~n;
      COND_VS: r = v;
      COND_VC: r = ~v;
      COND_HI: r = c & ~z;
      COND_LS: r = ~c | z;
      COND_GE: r = (n == v);
      COND_LT: r = (n != v);
      COND_GT: r = ~z & (n == v);
      COND_LE: r = z | (n != v);
      COND_AL: r = 1'b1;
      COND_NV: r = 1'b0;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/arm_cond_unit.sv
// arm_cond_unit: NZCV flag register, condition evaluation and masked flag updates.
// CondEx is captured once per instruction (in DECODE) and gates the later flag write.
module arm_cond_unit
  import arm_mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond_i,
  input  logic [3:0] aluFlags_i,
  input  logic       latchCond_i,
  input  logic       flagUpdate_i,
  input  logic       arithOp_i,
  output logic       condExNow_o,
  output logic       condEx_o
);

  logic [3:0] flags_q;
  logic       condEx_q;

  assign condExNow_o = condHolds(cond_i, flags_q);
  assign condEx_o    = condEx_q;

  // Capture CondEx in DECODE; load NZ always and CV only for arithmetic ops.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q  <= 4'b0000;
      condEx_q <= 1'b0;
    end else begin
      if (latchCond_i) begin
        condEx_q <= condExNow_o;
      end
      if (flagUpdate_i && condEx_q) begin
        flags_q[3:2] <= aluFlags_i[3:2];
        if (arithOp_i) begin
          flags_q[1:0] <= aluFlags_i[1:0];
        end
      end
    end
  end

endmodule

// File: rtl/arm_mc_controller.sv
// arm_mc_controller: multicycle ARM control FSM with memory ready handshake.
// Optional feature: define ARM_MC_BL_EN to let BRANCH write the link register (BL).
module arm_mc_controller
  import arm_mc_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Instr,
  input  logic [3:0]       ALUFlags,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             MemRead,
  output logic             AdrSrc,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ImmSrc,
  output logic [1:0]       RegSrc,
  output logic [ALUCW-1:0] ALUControl,
  output logic             BL,
  output logic [3:0]       State
);

  state_t state_q;

  logic [1:0] op;
  logic       immOp;
  logic [3:0] cmd;
  logic       sBit;
  logic       uBit;
  logic       lBit;
  logic       rdIsPc;
  logic       unusedInstr;
`ifdef ARM_MC_BL_EN
  logic       linkBit;
  assign linkBit = Instr[24];
`endif

  assign op          = Instr[27:26];
  assign immOp       = Instr[25];
  assign cmd         = Instr[24:21];
  assign sBit        = Instr[20];
  assign uBit        = Instr[23];
  assign lBit        = Instr[20];
  assign rdIsPc      = (Instr[15:12] == 4'hF);
  assign unusedInstr = ^{Instr[22], Instr[19:16], Instr[11:0]};
  assign State       = state_q;

  logic [ALUCW-1:0] dpAluCtl;
  logic             dpArith;
  logic             dpNoWrite;
  logic             dpNop;
  logic             condExNow;
  logic             condEx;

  // Map the data-processing command to an ALU op and its write/flag behaviour.
  always_comb begin
    dpAluCtl  = ALU_ADD;
    dpArith   = 1'b0;
    dpNoWrite = 1'b0;
    dpNop     = 1'b0;
    case (cmd)
      CMD_ADD: begin dpAluCtl = ALU_ADD;   dpArith = 1'b1; end
      CMD_SUB: begin dpAluCtl = ALU_SUB;   dpArith = 1'b1; end
      CMD_AND: dpAluCtl = ALU_AND;
      CMD_ORR: dpAluCtl = ALU_ORR;
      CMD_EOR: dpAluCtl = ALU_EOR;
      CMD_MOV: dpAluCtl = ALU_PASSB;
      CMD_CMP: begin dpAluCtl = ALU_SUB;   dpArith = 1'b1; dpNoWrite = 1'b1; end
      default: begin dpNop = 1'b1; dpNoWrite = 1'b1; end
    endcase
  end

  arm_cond_unit u_cond (
    .clk          (clk),
    .reset        (reset),
    .cond_i       (Instr[31:28]),
    .aluFlags_i   (ALUFlags),
    .latchCond_i  (state_q == S_DECODE),
    .flagUpdate_i (((state_q == S_EXECUTER) || (state_q == S_EXECUTEI)) && sBit && !dpNop),
    .arithOp_i    (dpArith),
    .condExNow_o  (condExNow),
    .condEx_o     (condEx)
  );

  // State sequencing; memory states hold until MemReady completes the access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:    if (MemReady) state_q <= S_DECODE;
        S_DECODE: begin
          if (!condExNow) begin
            state_q <= S_FETCH;
          end else begin
            case (op)
              2'b00:   state_q <= immOp ? S_EXECUTEI : S_EXECUTER;
              2'b01:   state_q <= S_MEMADR;
              2'b10:   state_q <= S_BRANCH;
              default: state_q <= S_FETCH;
            endcase
          end
        end
        S_MEMADR:   state_q <= lBit ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  if (MemReady) state_q <= S_MEMWB;
        S_MEMWB:    state_q <= S_FETCH;
        S_MEMWRITE: if (MemReady) state_q <= S_FETCH;
        S_EXECUTER,
        S_EXECUTEI: state_q <= S_ALUWB;
        S_ALUWB:    state_q <= S_FETCH;
        S_BRANCH:   state_q <= S_FETCH;
        default:    state_q <= S_FETCH;
      endcase
    end
  end

  // Per-state datapath controls; reset overrides every enable so nothing is written.
  always_comb begin
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    MemRead    = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_REG;
    ResultSrc  = RES_ALUOUT;
    ImmSrc     = IMM_8;
    RegSrc     = 2'b00;
    ALUControl = ALU_ADD;
    BL         = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = MemReady;
        PCWrite   = MemReady;
      end
      S_DECODE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_FOUR;
      end
      S_MEMADR: begin
        ALUSrcB    = SRCB_IMM;
        ImmSrc     = IMM_12;
        ALUControl = uBit ? ALU_ADD : ALU_SUB;
        RegSrc     = lBit ? 2'b00 : 2'b10;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        MemRead = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = RES_RDATA;
        RegWrite  = 1'b1;
        PCWrite   = rdIsPc;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        RegSrc   = 2'b10;
      end
      S_EXECUTER: ALUControl = dpAluCtl;
      S_EXECUTEI: begin
        ALUSrcB    = SRCB_IMM;
        ALUControl = dpAluCtl;
      end
      S_ALUWB: begin
        RegWrite = condEx & ~dpNoWrite;
        PCWrite  = condEx & ~dpNoWrite & rdIsPc;
      end
      S_BRANCH: begin
        RegSrc    = 2'b01;
        ALUSrcB   = SRCB_IMM;
        ImmSrc    = IMM_24;
        ResultSrc = RES_ALURESULT;
        PCWrite   = 1'b1;
`ifdef ARM_MC_BL_EN
        RegWrite  = linkBit;
        BL        = linkBit;
`else
        RegWrite  = 1'b0;
        BL        = 1'b0;
`endif
      end
      default: ;
    endcase
    if (reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      MemRead  = 1'b0;
    end
  end

endmodule
